// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - N-digit multiplexed seven-segment scan driver with frame-synchronous value load
// Optional anode PWM dimming via `define BRIGHTNESS_EN (adds brightness[3:0] input).
module seg_scan_driver #(
  parameter int N_DIGITS    = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*N_DIGITS-1:0]   load_value,
  input  logic [N_DIGITS-1:0]     load_dp,
  input  logic                    blank_lz,
`ifdef BRIGHTNESS_EN
  input  logic [3:0]              brightness,
`endif
  output logic                    frame_start,
  output logic [N_DIGITS-1:0]     anode,
  output logic [7:0]              cathode
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

  logic [PW-1:0]           r_presc;
  logic [IW-1:0]           r_index;
  logic                    r_pend_full;
  logic [4*N_DIGITS-1:0]   r_pend_value;
  logic [N_DIGITS-1:0]     r_pend_dp;
  logic [4*N_DIGITS-1:0]   r_disp_value;
  logic [N_DIGITS-1:0]     r_disp_dp;
  logic                    r_frame_start;
  logic [N_DIGITS-1:0]     r_anode;
  logic [7:0]              r_cathode;

  logic                    w_tick;
  logic                    w_boundary;
  logic                    w_accept;
  logic [3:0]              w_nibble;
  logic [6:0]              w_seg;
  logic [N_DIGITS-1:0]     w_upper_zero;
  logic                    w_blank;
  logic                    w_anode_on;
  logic [N_DIGITS-1:0]     w_anode_sel;
  logic [7:0]              w_cathode_nxt;

  assign w_tick     = (r_presc == PRESC_LAST);
  assign w_boundary = w_tick && (r_index == IDX_LAST);
  assign w_accept   = load_valid && !r_pend_full;
  assign w_nibble   = r_disp_value[{r_index, 2'b00} +: 4];

  // w_upper_zero[i]: this digit and every more significant one are zero
  always_comb begin
    w_upper_zero = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      w_upper_zero[i] = ((r_disp_value >> (4 * i)) == '0);
    end
  end

  assign w_blank = blank_lz && (r_index != '0) && w_upper_zero[r_index];

  always_comb begin
    w_seg = 7'h7F;
    case (w_nibble)
      4'h0: w_seg = 7'h40;
      4'h1: w_seg = 7'h79;
      4'h2: w_seg = 7'h24;
      4'h3: w_seg = 7'h30;
      4'h4: w_seg = 7'h19;
      4'h5: w_seg = 7'h12;
      4'h6: w_seg = 7'h02;
      4'h7: w_seg = 7'h78;
      4'h8: w_seg = 7'h00;
      4'h9: w_seg = 7'h10;
      4'hA: w_seg = 7'h08;
      4'hB: w_seg = 7'h03;
      4'hC: w_seg = 7'h46;
      4'hD: w_seg = 7'h21;
      4'hE: w_seg = 7'h06;
      4'hF: w_seg = 7'h0E;
      default: w_seg = 7'h7F;
    endcase
  end

  assign w_cathode_nxt = w_blank ? 8'hFF : {~r_disp_dp[r_index], w_seg};
  assign w_anode_sel   = ~({{(N_DIGITS-1){1'b0}}, 1'b1} << r_index);

`ifdef BRIGHTNESS_EN
  // Anode is lit only for the first (brightness+1)/16 of each slot.
  logic [31:0] w_duty_limit;
  assign w_duty_limit = ((32'(brightness) + 32'd1) * 32'(REFRESH_DIV)) >> 4;
  assign w_anode_on   = (32'(r_presc) < w_duty_limit);
`else
  assign w_anode_on = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc       <= '0;
      r_index       <= '0;
      r_pend_full   <= 1'b0;
      r_pend_value  <= '0;
      r_pend_dp     <= '0;
      r_disp_value  <= '0;
      r_disp_dp     <= '0;
      r_frame_start <= 1'b0;
      r_anode       <= '1;
      r_cathode     <= 8'hFF;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
      if (w_tick) begin
        r_index <= (r_index == IDX_LAST) ? '0 : r_index + IW'(1);
      end
      r_frame_start <= w_boundary;
      if (w_boundary && r_pend_full) begin
        r_disp_value <= r_pend_value;
        r_disp_dp    <= r_pend_dp;
      end
      // An accept can only happen while pending is empty, so a coincident
      // boundary has nothing to transfer and the new value stays pending.
      if (w_accept) begin
        r_pend_value <= load_value;
        r_pend_dp    <= load_dp;
        r_pend_full  <= 1'b1;
      end else if (w_boundary) begin
        r_pend_full  <= 1'b0;
      end
      r_anode   <= w_anode_on ? w_anode_sel : '1;
      r_cathode <= w_cathode_nxt;
    end
  end

  assign load_ready  = !r_pend_full;
  assign frame_start = r_frame_start;
  assign anode       = r_anode;
  assign cathode     = r_cathode;

endmodule
